// File: rtl/noc_pkg.sv
// Shared NoC constants: packet geometry, header field positions (big-endian
// bit numbering, bit 0 = MSB) and output-port indices.
package noc_pkg;

    localparam int DEF_PACKET_WIDTH = 64;
    localparam int DEF_HOP_WIDTH    = 8;

    localparam int VC_BIT = 0;
    localparam int DX_BIT = 1;
    localparam int DY_BIT = 2;
    localparam int HX_MSB = 8;
    localparam int HX_LSB = HX_MSB + DEF_HOP_WIDTH - 1;
    localparam int HY_MSB = 16;
    localparam int HY_LSB = HY_MSB + DEF_HOP_WIDTH - 1;

    localparam int NUM_PORTS = 5;
    localparam int PORT_E    = 0;
    localparam int PORT_W    = 1;
    localparam int PORT_N    = 2;
    localparam int PORT_S    = 3;
    localparam int PORT_PE   = 4;

endpackage

// File: rtl/noc_route_compute.sv
// Dimension-order (X then Y) route decision for one header, with the hop
// field of the chosen dimension decremented.
module noc_route_compute
    import noc_pkg::*;
#(
    parameter int HOP_WIDTH = DEF_HOP_WIDTH
) (
    input  logic                 i_dx,
    input  logic                 i_dy,
    input  logic [HOP_WIDTH-1:0] i_hx,
    input  logic [HOP_WIDTH-1:0] i_hy,
    output logic [NUM_PORTS-1:0] o_req,
    output logic [HOP_WIDTH-1:0] o_hx,
    output logic [HOP_WIDTH-1:0] o_hy
);

    // X hops are consumed first; a field is only decremented when non-zero.
    always_comb begin
        o_req = '0;
        o_hx  = i_hx;
        o_hy  = i_hy;
        if (i_hx != '0) begin
            if (i_dx) begin
                o_req[PORT_W] = 1'b1;
            end else begin
                o_req[PORT_E] = 1'b1;
            end
            o_hx = i_hx - HOP_WIDTH'(1);
        end else if (i_hy != '0) begin
            if (i_dy) begin
                o_req[PORT_S] = 1'b1;
            end else begin
                o_req[PORT_N] = 1'b1;
            end
            o_hy = i_hy - HOP_WIDTH'(1);
        end else begin
            o_req[PORT_PE] = 1'b1;
        end
    end

endmodule

// File: rtl/router_input_channel.sv
// Router input port: two one-packet VC buffers written/read on alternating
// polarity, with XY route request and hop-updated packet to the crossbar.
module router_input_channel
    import noc_pkg::*;
#(
    parameter int PACKET_WIDTH = DEF_PACKET_WIDTH,
    parameter int HOP_WIDTH    = DEF_HOP_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_si,
    output logic                    in_ri,
    input  logic [0:PACKET_WIDTH-1] in_di,
    output logic                    polarity,
    output logic [NUM_PORTS-1:0]    req,
    input  logic                    gnt,
    output logic [0:PACKET_WIDTH-1] dout,
    output logic [1:0]              vc_full
);

    logic                    r_polarity;
    logic [1:0]              r_vc_full;
    logic [0:PACKET_WIDTH-1] r_buf [2];

    logic                    w_wr_vc;
    logic                    w_rd_vc;
    logic [0:PACKET_WIDTH-1] w_rd_pkt;
    logic [NUM_PORTS-1:0]    w_req_raw;
    logic [HOP_WIDTH-1:0]    w_hx;
    logic [HOP_WIDTH-1:0]    w_hy;
    logic                    w_accept;
    logic                    w_release;

    assign w_wr_vc   = r_polarity;
    assign w_rd_vc   = ~r_polarity;
    assign w_rd_pkt  = r_buf[w_rd_vc];
    assign in_ri     = ~r_vc_full[w_wr_vc];
    assign w_accept  = in_si & in_ri;
    assign w_release = gnt & (req != '0);
    assign polarity  = r_polarity;
    assign vc_full   = r_vc_full;

    noc_route_compute #(
        .HOP_WIDTH (HOP_WIDTH)
    ) u_route (
        .i_dx  (w_rd_pkt[DX_BIT]),
        .i_dy  (w_rd_pkt[DY_BIT]),
        .i_hx  (w_rd_pkt[HX_MSB:HX_LSB]),
        .i_hy  (w_rd_pkt[HY_MSB:HY_LSB]),
        .o_req (w_req_raw),
        .o_hx  (w_hx),
        .o_hy  (w_hy)
    );

    // Crossbar view of the read VC; silent when that VC holds nothing.
    always_comb begin
        req  = '0;
        dout = '0;
        if (r_vc_full[w_rd_vc]) begin
            req                  = w_req_raw;
            dout                 = w_rd_pkt;
            dout[HX_MSB:HX_LSB]  = w_hx;
            dout[HY_MSB:HY_LSB]  = w_hy;
            dout[VC_BIT]         = w_rd_vc;
        end else begin
            req  = '0;
            dout = '0;
        end
    end

    // Polarity, buffers and valid bits; write and release always target different VCs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_polarity <= 1'b0;
            r_vc_full  <= 2'b00;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
        end else begin
            r_polarity <= ~r_polarity;
            if (w_accept) begin
                r_buf[w_wr_vc]     <= in_di;
                r_vc_full[w_wr_vc] <= 1'b1;
            end
            if (w_release) begin
                r_vc_full[w_rd_vc] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_router_input_channel.sv
// Self-checking bench for router_input_channel: directed scenarios plus a
// randomized run against a transaction-level model of the two VC slots.
module tb_router_input_channel;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_si;
    logic        in_ri;
    logic [0:63] in_di;
    logic        polarity;
    logic [4:0]  req;
    logic        gnt;
    logic [0:63] dout;
    logic [1:0]  vc_full;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: slot occupancy, slot contents and which slot is the write slot.
    logic        m_pol;
    logic [1:0]  m_full;
    logic [0:63] m_buf [2];

    router_input_channel dut (
        .clk      (clk),
        .reset    (reset),
        .in_si    (in_si),
        .in_ri    (in_ri),
        .in_di    (in_di),
        .polarity (polarity),
        .req      (req),
        .gnt      (gnt),
        .dout     (dout),
        .vc_full  (vc_full)
    );

    always #5 clk = ~clk;

    function automatic logic [0:63] rand64();
        logic [0:63] v;
        v = {$urandom, $urandom};
        return v;
    endfunction

    function automatic logic [0:63] make_pkt(input logic vc, input logic dx, input logic dy,
                                             input logic [7:0] hx, input logic [7:0] hy);
        logic [0:63] p;
        p        = rand64();
        p[0]     = vc;
        p[1]     = dx;
        p[2]     = dy;
        p[8:15]  = hx;
        p[16:23] = hy;
        return p;
    endfunction

    function automatic logic [4:0] exp_req(input logic [0:63] p);
        int hx = int'(p[8:15]);
        int hy = int'(p[16:23]);
        if (hx > 0) return p[1] ? 5'b00010 : 5'b00001;
        if (hy > 0) return p[2] ? 5'b01000 : 5'b00100;
        return 5'b10000;
    endfunction

    function automatic logic [0:63] exp_dout(input logic [0:63] p, input logic r);
        int hx = int'(p[8:15]);
        int hy = int'(p[16:23]);
        logic [0:63] d;
        d = p;
        if (hx > 0) d[8:15] = 8'(hx - 1);
        else if (hy > 0) d[16:23] = 8'(hy - 1);
        d[0] = r;
        return d;
    endfunction

    task automatic model_reset();
        m_pol    = 1'b0;
        m_full   = 2'b00;
        m_buf[0] = '0;
        m_buf[1] = '0;
    endtask

    task automatic model_update();
        logic acc, rel;
        acc = in_si && !m_full[m_pol];
        rel = gnt && m_full[~m_pol];
        if (acc) begin
            m_buf[m_pol]  = in_di;
            m_full[m_pol] = 1'b1;
        end
        if (rel) m_full[~m_pol] = 1'b0;
        m_pol = ~m_pol;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic wait_pol(input logic p);
        if (m_pol != p) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; in_si = 1'b0; in_di = '0; gnt = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({polarity, vc_full, in_ri, req, dout} !== {1'b0, 2'b00, 1'b1, 5'b00000, 64'h0}) begin
            n_fail++;
            $display("FAIL reset_state: pol=%b full=%b ri=%b req=%b dout=%h required 0 00 1 00000 0",
                     polarity, vc_full, in_ri, req, dout);
        end
        reset = 1'b1;
    endtask

    task automatic test_east();
        logic [0:63] p;
        wait_pol(1'b0);
        p = make_pkt(1'b1, 1'b0, 1'b0, 8'd3, 8'd0);
        in_si = 1'b1; in_di = p; gnt = 1'b0;
        tick();
        in_si = 1'b0;
        #1;
        n_tests++;
        if (req !== 5'b00001) begin
            n_fail++; $display("FAIL east_req: got %b required 00001", req);
        end
        n_tests++;
        if (dout[8:15] !== 8'd2 || dout[0] !== 1'b0) begin
            n_fail++; $display("FAIL east_dout: hx=%0d bit0=%b required hx=2 bit0=0", dout[8:15], dout[0]);
        end
        n_tests++;
        if (vc_full[0] !== 1'b1) begin
            n_fail++; $display("FAIL east_full: got %b required x1", vc_full);
        end
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        n_tests++;
        if (vc_full[0] !== 1'b0) begin
            n_fail++; $display("FAIL east_release: vc_full=%b required x0", vc_full);
        end
    endtask

    task automatic test_y_pe();
        logic [0:63] p, q;
        wait_pol(1'b0);
        p = make_pkt(1'b0, 1'b0, 1'b1, 8'd0, 8'd1);
        in_si = 1'b1; in_di = p;
        tick();
        in_si = 1'b0;
        #1;
        n_tests++;
        if (req !== 5'b01000 || dout[16:23] !== 8'd0 || dout[8:15] !== 8'd0) begin
            n_fail++; $display("FAIL south_route: req=%b hy=%0d hx=%0d required 01000 0 0", req, dout[16:23], dout[8:15]);
        end
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        wait_pol(1'b1);
        p = make_pkt(1'b0, 1'b1, 1'b1, 8'd0, 8'd0);
        q = p;
        q[0] = 1'b1;
        in_si = 1'b1; in_di = p;
        tick();
        in_si = 1'b0;
        #1;
        n_tests++;
        if (req !== 5'b10000 || dout !== q) begin
            n_fail++; $display("FAIL pe_route: req=%b dout=%h required 10000 %h", req, dout, q);
        end
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [0:63] a;
        wait_pol(1'b0);
        a = make_pkt(1'b1, 1'b1, 1'b0, 8'd5, 8'd2);
        in_si = 1'b1; in_di = a; gnt = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            in_si = (i % 2 == 1);
            in_di = rand64();
            #1;
            n_tests++;
            if (in_ri !== (i % 2 == 0)) begin
                n_fail++; $display("FAIL bp_ready[%0d]: ri=%b required %b", i, in_ri, (i % 2 == 0));
            end
            if (i % 2 == 0) begin
                n_tests++;
                if (dout !== exp_dout(a, 1'b0) || req !== 5'b00010) begin
                    n_fail++; $display("FAIL bp_hold[%0d]: dout=%h req=%b required %h 00010",
                                       i, dout, req, exp_dout(a, 1'b0));
                end
            end
            tick();
        end
        in_si = 1'b0;
        wait_pol(1'b1);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        n_tests++;
        if (vc_full !== 2'b00) begin
            n_fail++; $display("FAIL bp_drain: vc_full=%b required 00", vc_full);
        end
    endtask

    task automatic test_concurrent();
        logic [0:63] c, d;
        wait_pol(1'b1);
        c = make_pkt(1'b0, 1'b0, 1'b0, 8'd0, 8'd7);
        in_si = 1'b1; in_di = c; gnt = 1'b0;
        tick();
        d = make_pkt(1'b1, 1'b0, 1'b1, 8'd1, 8'd4);
        in_si = 1'b1; in_di = d; gnt = 1'b1;
        #1;
        n_tests++;
        if (req !== 5'b00100 || dout !== exp_dout(c, 1'b1)) begin
            n_fail++; $display("FAIL conc_vc1: req=%b dout=%h required 00100 %h", req, dout, exp_dout(c, 1'b1));
        end
        tick();
        in_si = 1'b0; gnt = 1'b0;
        #1;
        n_tests++;
        if (vc_full !== 2'b01) begin
            n_fail++; $display("FAIL conc_full: vc_full=%b required 01", vc_full);
        end
        n_tests++;
        if (req !== 5'b00001 || dout !== exp_dout(d, 1'b0)) begin
            n_fail++; $display("FAIL conc_vc0: req=%b dout=%h required 00001 %h", req, dout, exp_dout(d, 1'b0));
        end
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
    endtask

    task automatic test_zero();
        wait_pol(1'b0);
        in_si = 1'b1; in_di = 64'h0;
        tick();
        in_si = 1'b0;
        #1;
        n_tests++;
        if (vc_full !== 2'b01 || req !== 5'b10000 || dout !== 64'h0) begin
            n_fail++; $display("FAIL zero_pkt: full=%b req=%b dout=%h required 01 10000 0", vc_full, req, dout);
        end
        tick();
        n_tests++;
        if (in_ri !== 1'b0) begin
            n_fail++; $display("FAIL zero_ready_blocked: ri=%b required 0", in_ri);
        end
        tick();
        n_tests++;
        if (in_ri !== 1'b1) begin
            n_fail++; $display("FAIL zero_ready_other: ri=%b required 1", in_ri);
        end
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        n_tests++;
        if (in_ri !== 1'b1 || vc_full !== 2'b00) begin
            n_fail++; $display("FAIL zero_release: ri=%b full=%b required 1 00", in_ri, vc_full);
        end
    endtask

    task automatic test_reset_mid();
        wait_pol(1'b0);
        in_si = 1'b1; in_di = rand64(); gnt = 1'b0;
        tick();
        in_di = rand64();
        tick();
        in_si = 1'b0;
        #1;
        n_tests++;
        if (vc_full !== 2'b11) begin
            n_fail++; $display("FAIL rst_prefill: vc_full=%b required 11", vc_full);
        end
        @(posedge clk);
        model_update();
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if ({polarity, vc_full, in_ri, req, dout} !== {1'b0, 2'b00, 1'b1, 5'b00000, 64'h0}) begin
            n_fail++;
            $display("FAIL reset_mid: pol=%b full=%b ri=%b req=%b dout=%h required 0 00 1 00000 0",
                     polarity, vc_full, in_ri, req, dout);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [0:63] p;
        logic        r;
        for (int i = 0; i < 400; i++) begin
            p = make_pkt($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
                         8'($urandom_range(3, 0)), 8'($urandom_range(3, 0)));
            in_si = ($urandom_range(2, 0) != 0);
            in_di = p;
            gnt   = ($urandom_range(2, 0) == 0);
            #1;
            r = ~m_pol;
            n_tests++;
            if (polarity !== m_pol || vc_full !== m_full || in_ri !== ~m_full[m_pol]) begin
                n_fail++; $display("FAIL rand_state[%0d]: pol=%b full=%b ri=%b required %b %b %b",
                                   i, polarity, vc_full, in_ri, m_pol, m_full, ~m_full[m_pol]);
            end
            n_tests++;
            if (m_full[r]) begin
                if (req !== exp_req(m_buf[r]) || dout !== exp_dout(m_buf[r], r)) begin
                    n_fail++; $display("FAIL rand_out[%0d]: req=%b dout=%h required %b %h",
                                       i, req, dout, exp_req(m_buf[r]), exp_dout(m_buf[r], r));
                end
            end else begin
                if (req !== 5'b00000 || dout !== 64'h0) begin
                    n_fail++; $display("FAIL rand_idle[%0d]: req=%b dout=%h required 00000 0", i, req, dout);
                end
            end
            tick();
        end
        in_si = 1'b0;
        gnt   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_east();
        test_y_pe();
        test_backpressure();
        test_concurrent();
        test_zero();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/router_input_channel.md
Name: router_input_channel

Overview:
- Input-port stage of the mesh router, directly downstream of the NIC network output channel (or an upstream router's output port).
- Accepts 64-bit packets over the si/ri send/ready handshake into two one-packet virtual-channel buffers, even and odd.
- Generates the router polarity that alternates which VC is written externally and which is read internally.
- Computes the output-port request for the buffered packet and presents the hop-updated packet to the router crossbar.

Parameters:
PACKET_WIDTH, 64, packet width in bits; bit 0 is MSB (big-endian [0:PACKET_WIDTH-1] numbering)
HOP_WIDTH, 8, width of each hop-count field

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
in_si  in  1  upstream send strobe
in_ri  out  1  ready to upstream
in_di  in  PACKET_WIDTH  upstream packet
polarity  out  1  router polarity, also driven to attached NIC
req  out  5  one-hot output request [0]=E [1]=W [2]=N [3]=S [4]=PE
gnt  in  1  crossbar grant for the current req
dout  out  PACKET_WIDTH  packet to crossbar, hop field updated
vc_full  out  2  [0]=even VC valid, [1]=odd VC valid

Behaviour:
- Header fields:
  - bit 0 = vc
  - bit 1 = dx (0 east, 1 west)
  - bit 2 = dy (0 north, 1 south)
  - bits 3:7 reserved
  - bits 8:15 = hx, remaining x hops
  - bits 16:23 = hy, remaining y hops
  - bits 24:31 reserved
  - bits 32:63 = payload
- Reset (reset=0, async): polarity=0, vc_full=00, both buffers cleared. Consequently in_ri=1, req=00000, dout=0.
- Polarity: toggles on every rising edge after reset is released.
- Write side uses VC index w=polarity.
  - in_ri = ~vc_full[w], combinational.
  - On an edge with in_si & in_ri: buf[w] <= in_di and vc_full[w] <= 1.
  - in_si while in_ri=0: ignored, no state change, packet not captured (upstream must hold and retry).
- Occupancy is tracked by the valid bit only. An all-zero packet is a legal packet.
- Read side uses VC index r=~polarity.
  - When vc_full[r]=1, req is computed combinationally from buf[r]; otherwise req=00000 and dout=0.
  - Route, dimension-order XY:
    - hx!=0: E if dx=0, W if dx=1; dout hx = hx-1.
    - else hy!=0: N if dy=0, S if dy=1; dout hy = hy-1.
    - else: PE, hop fields unchanged.
  - dout bit 0 is forced to r. All other bits are copied unchanged.
  - Decrement never underflows, because a field is only decremented when it is non-zero.
- Grant:
  - On an edge with gnt=1 and req!=0: vc_full[r] <= 0 and the buffer is released.
  - gnt with req=00000 is ignored.
  - Without gnt, the packet stays and is re-requested two cycles later, when polarity returns to the same read VC.
- Simultaneous write of VC w and release of VC r in the same cycle: always legal, since w != r.
- Latency: a packet written at edge k is visible on req/dout in cycle k+1 (one cycle minimum). It is released at the first edge with gnt.
- Back-pressure: each VC holds one packet, so at most two packets are in flight. in_ri drops only for the cycle whose write VC is occupied.
- Reset asserted mid-operation discards buffered packets. No partial state survives.

Decomposition:
- Shared package noc_pkg:
  - PACKET_WIDTH and HOP_WIDTH defaults
  - header field bit positions (VC_BIT, DX_BIT, DY_BIT, HX_MSB/LSB, HY_MSB/LSB)
  - port index constants (PORT_E=0, PORT_W=1, PORT_N=2, PORT_S=3, PORT_PE=4)
- Sub-module noc_route_compute: purely combinational. Input: header. Outputs: one-hot req and updated hop fields.
- This module holds the polarity flop, the two VC buffers, the valid bits and the handshake logic.

Test Plan:
- Reset: drive reset=0 mid-cycle with both VCs full -> immediately polarity=0, vc_full=00, in_ri=1, req=00000, dout=0.
- East route: send hx=3, dx=0, hy=0 on polarity=0 -> next cycle req=00001, dout hx=2, dout bit0=0; assert gnt -> vc_full[0]=0 at that edge.
- Y then PE:
  - send hx=0, hy=1, dy=1 -> req=01000 (S), dout hy=0.
  - send hx=0, hy=0 -> req=10000 (PE), dout equals input with bit0=r.
- Back-pressure: fill VC0 with gnt held 0 -> in_ri=0 on every polarity=0 cycle, in_ri=1 on polarity=1 cycles. An in_si pulse during in_ri=0 is not captured, and the VC0 contents are unchanged.
- Concurrent: VC1 full and granted on the same edge that in_si writes VC0 -> VC0 valid, VC1 cleared, no data corruption.
- All-zero packet: send 64'h0 -> vc_full set, req=10000 (PE), in_ri drops on the matching polarity until gnt.
